// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: hazard unit for the 5-stage RV32 core.
// Handles M/W forwarding, the load-use interlock, branch/jump flushes,
// multi-cycle mul/div stall sequencing and I/D cache miss freezes.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  CpuClk,
  input  logic                  CpuRst,
  input  logic                  ICacheMiss,
  input  logic                  DCacheMiss,
  input  logic                  BranchE,
  input  logic                  JalrE,
  input  logic                  JalD,
  input  logic                  MdStartE,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [1:0]            RegReadD,
  input  logic [1:0]            RegReadE,
  input  logic                  MemToRegE,
  input  logic [2:0]            RegWriteM,
  input  logic [2:0]            RegWriteW,
  output logic                  StallF,
  output logic                  FlushF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  StallE,
  output logic                  FlushE,
  output logic                  StallM,
  output logic                  FlushM,
  output logic                  StallW,
  output logic                  FlushW,
  output logic [1:0]            Forward1E,
  output logic [1:0]            Forward2E,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      LuStallCnt,
  output logic [CNT_W-1:0]      DMissCycCnt,
  output logic [CNT_W-1:0]      MdStallCnt,
  output logic [CNT_W-1:0]      RedirCnt,
`endif
  output logic                  MdBusy
);

  // MD_LAT=1 still needs a legal (never loaded) one-bit counter
  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  // Elaboration-time sanity on parameters
  if (MD_LAT < 1 || CNT_W < 1 || REG_ADDR_W < 1) begin : g_bad_param
    $error("hazard_ctrl_mc: illegal parameter value");
  end

  logic [MD_W-1:0] r_md_cnt;
  logic            w_lu, w_re;
  logic            w_rule1, w_rule2, w_rule3;
  logic            w_md_start;

  assign MdBusy  = (r_md_cnt != '0);
  assign w_re    = BranchE | JalrE;
  assign w_lu    = MemToRegE & (RdE != '0) &
                   (((RdE == Rs1D) & RegReadD[1]) | ((RdE == Rs2D) & RegReadD[0]));
  assign w_rule1 = ~CpuRst & DCacheMiss;
  assign w_rule2 = ~CpuRst & ~DCacheMiss & MdBusy;
  assign w_rule3 = ~CpuRst & ~DCacheMiss & ~MdBusy;
  // EX is stalled under a D-miss or while busy, so a start only lands in rule 3
  assign w_md_start = (MD_LAT > 1) & MdStartE & w_rule3;

  // Forwarding: M beats W; computed regardless of stalls, masked in reset
  always_comb begin
    Forward1E = 2'b00;
    Forward2E = 2'b00;
    if (!CpuRst) begin
      if ((RegWriteM != '0) && (RdM != '0) && (RdM == Rs1E) && RegReadE[1])      Forward1E = 2'b10;
      else if ((RegWriteW != '0) && (RdW != '0) && (RdW == Rs1E) && RegReadE[1]) Forward1E = 2'b01;
      if ((RegWriteM != '0) && (RdM != '0) && (RdM == Rs2E) && RegReadE[0])      Forward2E = 2'b10;
      else if ((RegWriteW != '0) && (RdW != '0) && (RdW == Rs2E) && RegReadE[0]) Forward2E = 2'b01;
    end
  end

  // Stall/flush priority: reset, D-miss freeze, mul/div occupancy, then normal hazards
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0; StallW = 1'b0;
    FlushF = 1'b0; FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (CpuRst) begin
      FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
    end else if (DCacheMiss) begin
      // EX/ID contents re-present next cycle, so redirects wait
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (MdBusy) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      // A redirect kills the dependent instruction and lets the PC take the target
      StallF = (w_lu | ICacheMiss) & ~w_re;
      StallD = w_lu & ~w_re;
      FlushE = w_re | w_lu;
      FlushD = w_re | JalD | (ICacheMiss & ~w_lu);
    end
  end

  // Mul/div occupancy counter; decrements through cache misses
  always_ff @(posedge CpuClk) begin
    if (CpuRst)          r_md_cnt <= '0;
    else if (w_md_start) r_md_cnt <= MD_W'(MD_LAT - 1);
    else if (MdBusy)     r_md_cnt <= r_md_cnt - 1'b1;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_lu_cnt, r_dm_cnt, r_md_stall_cnt, r_redir_cnt;
  logic             w_ev_lu, w_ev_redir;

  assign w_ev_lu    = w_rule3 & w_lu & ~w_re;
  assign w_ev_redir = w_rule3 & (w_re | JalD);

  // Saturating event counters
  always_ff @(posedge CpuClk) begin
    if (CpuRst) begin
      r_lu_cnt       <= '0;
      r_dm_cnt       <= '0;
      r_md_stall_cnt <= '0;
      r_redir_cnt    <= '0;
    end else begin
      if (w_ev_lu    && ~&r_lu_cnt)       r_lu_cnt       <= r_lu_cnt + 1'b1;
      if (w_rule1    && ~&r_dm_cnt)       r_dm_cnt       <= r_dm_cnt + 1'b1;
      if (w_rule2    && ~&r_md_stall_cnt) r_md_stall_cnt <= r_md_stall_cnt + 1'b1;
      if (w_ev_redir && ~&r_redir_cnt)    r_redir_cnt    <= r_redir_cnt + 1'b1;
    end
  end

  assign LuStallCnt  = r_lu_cnt;
  assign DMissCycCnt = r_dm_cnt;
  assign MdStallCnt  = r_md_stall_cnt;
  assign RedirCnt    = r_redir_cnt;
`endif

endmodule
